fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 44 ++++
 rtl/fetch_unit.sv | 99 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: pipeline stall and redirect inputs, instruction RAM
// request/response, and the descriptor and instruction handed to decode.
// master = fetch unit side, slave = environment (pipeline control, RAM, decode).

`ifndef StallBus
`define StallBus 2
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif

interface fetch_unit_if;
    logic [`StallBus-1:0]    stall;
    logic [`BR_WD-1:0]       br_bus;
    logic [31:0]             inst_sram_rdata;
    logic [`IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                    inst_sram_en;
    logic [3:0]              inst_sram_wen;
    logic [31:0]             inst_sram_addr;
    logic [31:0]             inst_sram_wdata;
    logic [31:0]             inst_o;
    logic                    fetch_adel;

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, inst_o, fetch_adel
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, inst_o, fetch_adel
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with branch redirect, redirect capture
// while fetch is stalled, and a one-entry hold buffer that keeps the fetched
// instruction stable while decode is stalled.
// Optional feature macro: FETCH_ADDR_ALIGN_CHECK_EN enables misaligned-PC
// detection (fetch_adel) and suppresses the RAM request for a misaligned PC.

module fetch_unit (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fetch_io
);

    localparam logic [31:0] ResetPc = 32'hBFBF_FFFC;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic        ce_q;
    logic        br_pend_q;
    logic [31:0] br_pend_addr_q;
    logic        hold_valid_q;
    logic [31:0] hold_inst_q;
    logic        fetch_stop;
    logic        decode_stop;

    assign br_e        = fetch_io.br_bus[32];
    assign br_addr     = fetch_io.br_bus[31:0];
    assign fetch_stop  = (fetch_io.stall[0] == `Stop);
    assign decode_stop = (fetch_io.stall[1] == `Stop);

    // Next PC: a redirect captured during a stall beats any br_e on release.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (br_pend_q) begin
            pc_d = br_pend_addr_q;
        end else if (br_e) begin
            pc_d = br_addr;
        end
    end

    // PC advance, or hold the PC and remember the newest redirect while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= ResetPc;
            ce_q           <= 1'b0;
            br_pend_q      <= 1'b0;
            br_pend_addr_q <= 32'h0;
        end else if (!fetch_stop) begin
            pc_q      <= pc_d;
            ce_q      <= 1'b1;
            br_pend_q <= 1'b0;
        end else if (br_e) begin
            br_pend_q      <= 1'b1;
            br_pend_addr_q <= br_addr;
        end
    end

    // Capture the RAM word on the first decode-stall cycle; release one cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_inst_q  <= 32'h0;
        end else if (decode_stop && !hold_valid_q) begin
            hold_valid_q <= 1'b1;
            hold_inst_q  <= fetch_io.inst_sram_rdata;
        end else if (!decode_stop) begin
            hold_valid_q <= 1'b0;
        end
    end

`ifdef FETCH_ADDR_ALIGN_CHECK_EN
    logic adel_q;

    // Flag tracks the alignment of whatever PC gets loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else if (!fetch_stop) begin
            adel_q <= (pc_d[1:0] != 2'b00);
        end
    end

    assign fetch_io.fetch_adel   = adel_q;
    assign fetch_io.inst_sram_en = ce_q & ~adel_q;
`else
    assign fetch_io.fetch_adel   = 1'b0;
    assign fetch_io.inst_sram_en = ce_q;
`endif

    assign fetch_io.inst_sram_addr  = pc_q;
    assign fetch_io.inst_sram_wen   = 4'b0000;
    assign fetch_io.inst_sram_wdata = 32'h0;
    // Descriptor is all-zero while no valid fetch exists (reset/pre-start), so
    // decode never sees the reset PC as a stale address.
    assign fetch_io.if_to_id_bus    = ce_q ? {1'b1, pc_q} : '0;
    assign fetch_io.inst_o          = hold_valid_q ? hold_inst_q : fetch_io.inst_sram_rdata;

endmodule
